// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM encoding, the clamp ceiling and the step-counter width.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int MAX_DEC = 9999;
  localparam int COUNT_W = 5;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus between a requester and bin2bcd_seq.
// The converter sits on the slave side; the requester or bench sits on the master side.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);

  logic             start;
  logic [BIN_W-1:0] bin;
  logic [15:0]      bcd;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start,
    output bin,
    input  bcd,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output bcd,
    output busy,
    output done,
    output ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
// The result stays within the nibble, so no carry passes to the next digit.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter that performs one shift per clock.
// Results go to bcd/ovf only at completion, so the display never shows partial values.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input logic            clk,
  input logic            rst,
  bin2bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [SR_W-1:0]      shift_q, shift_d;
  logic [SR_W-1:0]      adjusted;
  logic [SR_W-1:0]      shifted;
  logic                 pendOvf_q, pendOvf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  // Each digit is corrected on its own; the binary part passes through unchanged.
  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_add3 uAdd3 (
      .digit_i (shift_q[BIN_W + 4*g +: 4]),
      .digit_o (adjusted[BIN_W + 4*g +: 4])
    );
  end

  assign adjusted[BIN_W-1:0] = shift_q[BIN_W-1:0];
  assign shifted             = adjusted << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      pendOvf_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      pendOvf_q <= pendOvf_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    pendOvf_d = pendOvf_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          count_d = '0;
          // Values above 9999 do not fit in four digits, so they show as 9999 with ovf set.
          if (32'(bus.bin) > MAX_DEC) begin
            shift_d   = {{BCD_W{1'b0}}, BIN_W'(MAX_DEC)};
            pendOvf_d = 1'b1;
          end else begin
            shift_d   = {{BCD_W{1'b0}}, bus.bin};
            pendOvf_d = 1'b0;
          end
        end
      end

      SHIFT: begin
        shift_d = shifted;
        count_d = count_q + 1'b1;
        if (count_q == COUNT_W'(BIN_W - 1)) begin
          state_d = IDLE;
          bcd_d   = shifted[SR_W-1:BIN_W];
          ovf_d   = pendOvf_q;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q == SHIFT);

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble) with start/done handshake.
- Sits directly upstream of the 4-digit seven-segment display controller. Its bcd output drives that controller's 16-bit number input, so a binary value appears as decimal digits.
- The output register changes only at completion. The display never shows intermediate shift values.

Parameters:
- BIN_W, 14, width of binary input (valid range 14..16). One shift cycle per bit.
- DIGITS, 4, number of BCD digits. Fixed at 4 in this revision, to match the display.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request conversion. Sampled on rising clk edge; accepted only when busy=0.
- bin  in  BIN_W  unsigned binary value. Captured on the edge that accepts start.
- bcd  out  16  result, 4 packed BCD nibbles. [15:12] = thousands, [3:0] = units.
- busy  out  1  conversion in progress
- done  out  1  single-cycle pulse; bcd/ovf updated in the same cycle
- ovf  out  1  last converted value exceeded 9999 and was clamped

Behaviour:
- Reset, asynchronous and active-high; takes effect immediately, including mid-conversion:
  - state=IDLE, shift/count registers cleared.
  - bcd=16'h0000, busy=0, done=0, ovf=0.
  - No done pulse follows a reset-aborted conversion.
- State machine, 2 states: IDLE, SHIFT.
- IDLE:
  - If start=1 at edge k: capture clamped value into the binary part of the shift register, clear BCD part, count=0, busy=1, go to SHIFT.
  - Clamp rule: if bin > 9999, load 9999 and set pending_ovf=1; else load bin, pending_ovf=0.
- SHIFT, one step per edge:
  - Each BCD nibble >= 5 gets +3, then the whole {bcd,bin} register shifts left 1.
  - count increments each step.
  - On the step where count == BIN_W-1 (edge k+BIN_W): bcd <= post-shift BCD part, ovf <= pending_ovf, done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge k, result visible after edge k+BIN_W (k+14 by default). busy high for exactly BIN_W cycles.
- done: high for exactly one cycle, otherwise 0.
- start while busy=1: ignored, no queuing. The captured bin is unaffected by later changes on bin.
- start in the done cycle: accepted (state is IDLE). Back-to-back throughput is one result per BIN_W cycles.
- Holding behaviour: bcd and ovf hold their last values indefinitely between conversions, and while busy.
- Width rules:
  - Shift register is 16+BIN_W bits.
  - Add-3 is applied per nibble, 4-bit, with no carry between nibbles.
  - With clamped input <= 9999, no digit exceeds 9.

Decomposition:
- Package bin2bcd_pkg:
  - state encoding (IDLE=1'b0, SHIFT=1'b1)
  - MAX_DEC = 9999
  - COUNT_W = 5
- Sub-module bcd_add3: combinational, 4-bit in/out, adds 3 when the input is >= 5. Instantiated 4 times on the BCD part before the shift.

Test Plan:
- Reset, then start with bin=0 → busy high 14 cycles, done pulse at edge k+14, bcd=16'h0000, ovf=0.
- bin=1234 → bcd=16'h1234 exactly 14 cycles after the start edge; bcd stays at its previous value while busy.
- Boundary values:
  - bin=9999 → bcd=16'h9999, ovf=0.
  - Then bin=12000 → bcd=16'h9999, ovf=1.
  - Then bin=16383 → 16'h9999, ovf=1.
- Start with bin=567, then pulse start with bin=42 and toggle bin while busy → result 16'h0567; single done pulse.
- Start with bin=42 in the exact done cycle of a prior conversion → accepted; second done 14 cycles later with bcd=16'h0042.
- Assert rst at cycle 7 of a conversion of 8888 → bcd=0, busy=0, done=0 immediately; no done afterward. A new start after release yields the correct result.
